// File: rtl/mc_wport_arbiter.sv
// Round-robin arbiter and write sequencer for the single write port of an MC_DFF31 register bank.
// A grant holds WE for SETTLE cycles, then pulses a one-hot ACK to the winning requester.
module mc_wport_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned AW     = 3,
   parameter int unsigned SETTLE = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N-1:0]         i_req,
   input  logic [N*AW-1:0]      i_addr,
   input  logic [N*WIDTH-1:0]   i_wdata,
   output logic [N-1:0]         o_ack,
   output logic                 o_busy,
   output logic [$clog2(N)-1:0] o_gnt_id,
   output logic                 o_we,
   output logic [AW-1:0]        o_waddr,
   output logic [WIDTH-1:0]     o_wd
);

   localparam int unsigned IW  = $clog2(N);
   localparam int unsigned IWP = IW + 1;
   localparam int unsigned CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StDone
   } state_e;

   state_e           r_state;
   logic [IW-1:0]    r_ptr;
   logic [CW-1:0]    r_cnt;
   logic             r_we;
   logic [AW-1:0]    r_waddr;
   logic [WIDTH-1:0] r_wd;
   logic [N-1:0]     r_ack;
   logic [IW-1:0]    r_gnt_id;
   logic             r_busy;

   state_e           w_state_nxt;
   logic [IW-1:0]    w_ptr_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_we_nxt;
   logic [AW-1:0]    w_waddr_nxt;
   logic [WIDTH-1:0] w_wd_nxt;
   logic [N-1:0]     w_ack_nxt;
   logic [IW-1:0]    w_gnt_id_nxt;
   logic             w_busy_nxt;

   logic [AW-1:0]    w_addr_arr [N];
   logic [WIDTH-1:0] w_data_arr [N];

   logic [IW:0]      w_sum;
   logic [IW-1:0]    w_idx;
   logic             w_found;
   logic [IW-1:0]    w_winner;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_addr_arr[i] = i_addr[i*AW +: AW];
         w_data_arr[i] = i_wdata[i*WIDTH +: WIDTH];
      end
   end

   // Scan PTR, PTR+1, ... modulo N; the first requester found wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_sum = {1'b0, r_ptr} + IWP'(k);
         if (w_sum >= IWP'(N)) begin
            w_sum = w_sum - IWP'(N);
         end
         w_idx = w_sum[IW-1:0];
         if (!w_found && i_req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_cnt_nxt    = r_cnt;
      w_we_nxt     = r_we;
      w_waddr_nxt  = r_waddr;
      w_wd_nxt     = r_wd;
      w_ack_nxt    = '0;
      w_gnt_id_nxt = r_gnt_id;
      w_busy_nxt   = r_busy;
      unique case (r_state)
         StIdle: begin
            w_we_nxt   = 1'b0;
            w_busy_nxt = 1'b0;
            if (w_found) begin
               w_waddr_nxt  = w_addr_arr[w_winner];
               w_wd_nxt     = w_data_arr[w_winner];
               w_gnt_id_nxt = w_winner;
               w_cnt_nxt    = CW'(SETTLE - 1);
               w_we_nxt     = 1'b1;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = StWrite;
            end
         end
         StWrite: begin
            if (r_cnt == '0) begin
               w_we_nxt            = 1'b0;
               w_ack_nxt[r_gnt_id] = 1'b1;
               w_state_nxt         = StDone;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StDone: begin
            w_ptr_nxt   = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = StIdle;
         end
         default: begin
            w_we_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Reset abandons any write in flight without advancing the pointer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wd     <= '0;
         r_ack    <= '0;
         r_gnt_id <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_we     <= w_we_nxt;
         r_waddr  <= w_waddr_nxt;
         r_wd     <= w_wd_nxt;
         r_ack    <= w_ack_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign o_ack    = r_ack;
   assign o_busy   = r_busy;
   assign o_gnt_id = r_gnt_id;
   assign o_we     = r_we;
   assign o_waddr  = r_waddr;
   assign o_wd     = r_wd;

endmodule

// File: tb/tb_mc_wport_arbiter.sv
// Bench for mc_wport_arbiter: directed timing scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-timeline model of the arbiter.
module tb_mc_wport_arbiter;

   localparam int unsigned N      = 4;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned AW     = 3;
   localparam int unsigned SETTLE = 2;
   localparam int unsigned IW     = $clog2(N);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N-1:0]         req = '0;
   logic [N*AW-1:0]      addr = '0;
   logic [N*WIDTH-1:0]   wdata = '0;
   logic [N-1:0]         ack;
   logic                 busy;
   logic [IW-1:0]        gnt_id;
   logic                 we;
   logic [AW-1:0]        waddr;
   logic [WIDTH-1:0]     wd;

   int n_tests = 0;
   int n_fail  = 0;

   mc_wport_arbiter #(
      .N      (N),
      .WIDTH  (WIDTH),
      .AW     (AW),
      .SETTLE (SETTLE)
   ) u_dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_req    (req),
      .i_addr   (addr),
      .i_wdata  (wdata),
      .o_ack    (ack),
      .o_busy   (busy),
      .o_gnt_id (gnt_id),
      .o_we     (we),
      .o_waddr  (waddr),
      .o_wd     (wd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: m_phase counts cycles since the grant edge (0 = idle). Phases 1..SETTLE carry WE,
   // phase SETTLE+1 carries the ACK, and the following edge returns to idle.
   int               m_phase = 0;
   int               m_ptr   = 0;
   int               m_gnt   = 0;
   logic [AW-1:0]    m_addr  = '0;
   logic [WIDTH-1:0] m_data  = '0;

   always @(posedge clk) begin : model
      int idx;
      bit found;
      if (rst) begin
         m_phase = 0;
         m_ptr   = 0;
         m_gnt   = 0;
         m_addr  = '0;
         m_data  = '0;
      end else if (m_phase == 0) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && req[idx]) begin
               found   = 1;
               m_gnt   = idx;
               m_addr  = addr[idx*AW +: AW];
               m_data  = wdata[idx*WIDTH +: WIDTH];
               m_phase = 1;
            end
         end
      end else if (m_phase == SETTLE + 1) begin
         m_ptr   = (m_gnt + 1) % N;
         m_phase = 0;
      end else begin
         m_phase++;
      end
      #1;
      chk("model_we", 32'(we), 32'(m_phase >= 1 && m_phase <= SETTLE));
      chk("model_ack", 32'(ack), (m_phase == SETTLE + 1) ? (32'd1 << m_gnt) : 32'd0);
      chk("model_busy", 32'(busy), 32'(m_phase != 0));
      chk("model_gnt_id", 32'(gnt_id), 32'(m_gnt));
      chk("model_waddr", 32'(waddr), 32'(m_addr));
      chk("model_wd", 32'(wd), 32'(m_data));
   end

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      req   = '0;
      addr  = '0;
      wdata = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Single write, then late withdrawal/data change, then pointer check.
      do_reset();
      chk("rst_we", 32'(we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_gnt_id", 32'(gnt_id), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wd", 32'(wd), 0);
      addr[0 +: AW]     = 3'd5;
      wdata[0 +: WIDTH] = 8'hA5;
      req               = 4'b0001;
      @(negedge clk);
      chk("t1_we_c1", 32'(we), 1);
      chk("t1_waddr_c1", 32'(waddr), 5);
      chk("t1_wd_c1", 32'(wd), 32'hA5);
      chk("t1_busy_c1", 32'(busy), 1);
      req[0]            = 1'b0;
      wdata[0 +: WIDTH] = 8'h3C;
      @(negedge clk);
      chk("t1_we_c2", 32'(we), 1);
      chk("t1_wd_c2", 32'(wd), 32'hA5);
      chk("t1_ack_c2", 32'(ack), 0);
      @(negedge clk);
      chk("t1_ack_c3", 32'(ack), 32'b0001);
      chk("t1_we_c3", 32'(we), 0);
      chk("t1_busy_c3", 32'(busy), 1);
      @(negedge clk);
      chk("t1_busy_c4", 32'(busy), 0);
      chk("t1_ack_c4", 32'(ack), 0);
      chk("t1_wd_hold_c4", 32'(wd), 32'hA5);
      req = 4'b0011;
      @(negedge clk);
      chk("t1_ptr_gnt_c5", 32'(gnt_id), 1);
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      chk("t1_ack_c7", 32'(ack), 32'b0010);

      // All requesters continuously, each dropped on its own ACK.
      do_reset();
      req = 4'b1111;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         chk("t2_we", 32'(we), 32'((c % 4 == 1) || (c % 4 == 2)));
         chk("t2_ack", 32'(ack), (c % 4 == 3) ? (32'd1 << (c / 4)) : 32'd0);
         if (c % 4 == 1) chk("t2_gnt", 32'(gnt_id), 32'(c / 4));
         req = req & ~ack;
      end

      // Pointer at 2 after grants 0 and 1; a new 0011 request must wrap to 0.
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1 || c == 9) chk("t3_gnt0", 32'(gnt_id), 0);
         if (c == 5 || c == 13) chk("t3_gnt1", 32'(gnt_id), 1);
         if (c == 3 || c == 11) chk("t3_ack0", 32'(ack), 32'b0001);
         if (c == 7 || c == 15) chk("t3_ack1", 32'(ack), 32'b0010);
         req = req & ~ack;
         if (c == 8) req = 4'b0011;
      end

      // Reset during WRITE abandons the write and leaves the pointer at 0.
      do_reset();
      addr[AW +: AW]        = 3'd6;
      wdata[WIDTH +: WIDTH] = 8'h77;
      req                   = 4'b0010;
      @(negedge clk);
      chk("t5_gnt_c1", 32'(gnt_id), 1);
      chk("t5_we_c1", 32'(we), 1);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0000;
      @(negedge clk);
      chk("t5_we_c3", 32'(we), 0);
      chk("t5_busy_c3", 32'(busy), 0);
      chk("t5_ack_c3", 32'(ack), 0);
      chk("t5_gnt_c3", 32'(gnt_id), 0);
      chk("t5_waddr_c3", 32'(waddr), 0);
      rst = 1'b0;
      for (int c = 4; c <= 8; c++) begin
         @(negedge clk);
         chk("t5_no_ack", 32'(ack), 0);
      end
      req = 4'b0110;
      @(negedge clk);
      chk("t5_ptr0_gnt", 32'(gnt_id), 1);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // REQ0 held through its ACK is a fresh request.
      do_reset();
      addr[0 +: AW]     = 3'd2;
      wdata[0 +: WIDTH] = 8'h11;
      req               = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("t6_we", 32'(we), 32'(c == 1 || c == 2 || c == 5 || c == 6));
         chk("t6_ack", 32'(ack), (c == 3 || c == 7) ? 32'b0001 : 32'd0);
         if (c == 7) req = 4'b0000;
      end

      // Random traffic with occasional resets; the model checks every cycle.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 249) == 0);
         for (int i = 0; i < N; i++) begin
            if (ack[i]) req[i] = ($urandom_range(0, 3) == 0);
            else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
            else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) addr[i*AW +: AW] = AW'($urandom);
            if ($urandom_range(0, 1) == 1) wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
